// File: rtl/ram_pkg.sv
// Shared types and helpers for the simple-dual-port RAM and its clear sequencer.
package ram_pkg;

  typedef enum logic [0:0] {
    RDW_READ_FIRST,
    RDW_WRITE_FIRST
  } rdw_mode_e;

  typedef enum logic [0:0] {
    ST_CLEAR,
    ST_READY
  } ram_state_e;

  // Address width for n words, never below 1 so a 1-word RAM still has a port.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) w++;
    return w;
  endfunction

endpackage

// File: rtl/sync_ram_dp_if.sv
// Read/write port bundle of sync_ram_dp; master is the user side, slave is the RAM.
interface sync_ram_dp_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned GRAN       = 8
);
  localparam int unsigned LANES = DATA_WIDTH / GRAN;

  logic [ADDR_WIDTH-1:0] wr_adr;
  logic [DATA_WIDTH-1:0] wr_dat;
  logic                  wr_en;
  logic [LANES-1:0]      wr_sel;
  logic [ADDR_WIDTH-1:0] rd_adr;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_dat;
  logic                  rd_valid;
  logic                  ready;

  modport master (
    output wr_adr, wr_dat, wr_en, wr_sel, rd_adr, rd_en,
    input  rd_dat, rd_valid, ready
  );

  modport slave (
    input  wr_adr, wr_dat, wr_en, wr_sel, rd_adr, rd_en,
    output rd_dat, rd_valid, ready
  );

endinterface

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, then raises ready.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_adr,
  output logic                  ready
);

  localparam logic [ADDR_WIDTH-1:0] LastAdr = ADDR_WIDTH'(DEPTH - 1);

  ram_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == ST_READY);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    if (state_q == ST_CLEAR) begin
      clr_we = 1'b1;
      cnt_d  = cnt_q + 1'b1;
      if (cnt_q == LastAdr) begin
        state_d = ST_READY;
        cnt_d   = '0;
      end
    end
  end

  assign clr_adr = cnt_q;
  assign ready   = ready_q;

endmodule

// File: rtl/sync_ram_dp.sv
// Simple-dual-port synchronous RAM with byte-lane writes, selectable read-during-write
// behaviour, optional output register and a hardware clear after reset.
module sync_ram_dp
  import ram_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH     = 8,
  parameter int unsigned           DEPTH          = 16,
  parameter int unsigned           GRAN           = 8,
  parameter int unsigned           RDW_MODE       = 0,
  parameter int unsigned           OUT_REG        = 0,
  parameter int unsigned           CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input logic          clk,
  input logic          rst,
  sync_ram_dp_if.slave bus
);

  localparam int unsigned    ADDR_WIDTH = clog2(DEPTH);
  localparam int unsigned    LANES      = DATA_WIDTH / GRAN;
  localparam int unsigned    Aw1        = ADDR_WIDTH + 1;
  localparam logic [Aw1-1:0] DepthW     = Aw1'(DEPTH);
  localparam rdw_mode_e      RdwMode    = (RDW_MODE != 0) ? RDW_WRITE_FIRST : RDW_READ_FIRST;

  if (DATA_WIDTH % GRAN != 0) begin : g_bad_width
    $fatal(1, "sync_ram_dp: DATA_WIDTH must be a multiple of GRAN");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  clr_we, ready;
  logic [ADDR_WIDTH-1:0] clr_adr;

  ram_clear_seq #(
    .DEPTH          (DEPTH),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk     (clk),
    .rst     (rst),
    .clr_we  (clr_we),
    .clr_adr (clr_adr),
    .ready   (ready)
  );

  logic                  wr_in_range, rd_in_range, user_we, rd_fire, we;
  logic [ADDR_WIDTH-1:0] we_adr;
  logic [DATA_WIDTH-1:0] we_dat, rd_word;
  logic [LANES-1:0]      we_sel;

  // The clear sequencer owns the single write port while it runs.
  always_comb begin
    wr_in_range = {1'b0, bus.wr_adr} < DepthW;
    rd_in_range = {1'b0, bus.rd_adr} < DepthW;
    user_we     = ready && bus.wr_en && wr_in_range;
    rd_fire     = ready && bus.rd_en;
    we          = clr_we || user_we;
    we_adr      = clr_we ? clr_adr : bus.wr_adr;
    we_dat      = clr_we ? CLEAR_VALUE : bus.wr_dat;
    we_sel      = clr_we ? '1 : bus.wr_sel;
    rd_word     = '0;
    if (rd_in_range) begin
      rd_word = mem[bus.rd_adr];
      if (RdwMode == RDW_WRITE_FIRST && user_we && bus.wr_adr == bus.rd_adr) begin
        for (int i = 0; i < LANES; i++) begin
          if (bus.wr_sel[i]) rd_word[i*GRAN +: GRAN] = bus.wr_dat[i*GRAN +: GRAN];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (we_sel[i]) mem[we_adr][i*GRAN +: GRAN] <= we_dat[i*GRAN +: GRAN];
      end
    end
  end

  logic [DATA_WIDTH-1:0] s1_dat_q, rd_dat_q;
  logic                  s1_vld_q, rd_vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_dat_q <= '0;
      s1_vld_q <= 1'b0;
      rd_dat_q <= '0;
      rd_vld_q <= 1'b0;
    end else if (OUT_REG != 0) begin
      s1_vld_q <= rd_fire;
      if (rd_fire) s1_dat_q <= rd_word;
      rd_vld_q <= s1_vld_q;
      if (s1_vld_q) rd_dat_q <= s1_dat_q;
    end else begin
      rd_vld_q <= rd_fire;
      if (rd_fire) rd_dat_q <= rd_word;
    end
  end

  assign bus.rd_dat   = rd_dat_q;
  assign bus.rd_valid = rd_vld_q;
  assign bus.ready    = ready;

endmodule

// File: tb/tb_sync_ram_dp.sv
// Two RAM configurations driven by shared random traffic, checked against a word-array model.
module tb_sync_ram_dp;
  import ram_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  wr_adr, rd_adr, wr_sel;
  logic [31:0] wr_dat;
  logic        wr_en, rd_en;

  // dut0: 32-bit, 4 lanes, 12 words, read-first, no output reg, fill A5A55A5A
  // dut1: 16-bit, 2 lanes, 16 words, write-first, output reg, fill 0
  sync_ram_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .GRAN(8)) bus0 ();
  sync_ram_dp_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .GRAN(8)) bus1 ();

  assign bus0.wr_adr = wr_adr;
  assign bus0.wr_dat = wr_dat;
  assign bus0.wr_en  = wr_en;
  assign bus0.wr_sel = wr_sel;
  assign bus0.rd_adr = rd_adr;
  assign bus0.rd_en  = rd_en;
  assign bus1.wr_adr = wr_adr;
  assign bus1.wr_dat = wr_dat[15:0];
  assign bus1.wr_en  = wr_en;
  assign bus1.wr_sel = wr_sel[1:0];
  assign bus1.rd_adr = rd_adr;
  assign bus1.rd_en  = rd_en;

  sync_ram_dp #(
    .DATA_WIDTH(32), .DEPTH(12), .GRAN(8), .RDW_MODE(0), .OUT_REG(0),
    .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'hA5A5_5A5A)
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  sync_ram_dp #(
    .DATA_WIDTH(16), .DEPTH(16), .GRAN(8), .RDW_MODE(1), .OUT_REG(1),
    .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'h0000)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int          depth_c [2] = '{12, 16};
  int          lanes_c [2] = '{4, 2};
  int          rdw_c   [2] = '{0, 1};
  int          oreg_c  [2] = '{0, 1};
  logic [31:0] mask_c  [2] = '{32'hFFFF_FFFF, 32'h0000_FFFF};
  logic [31:0] clrv_c  [2] = '{32'hA5A5_5A5A, 32'h0000_0000};

  typedef struct {
    logic [31:0] dat;
    int          due;
  } exp_t;

  exp_t        q0[$], q1[$];
  logic [31:0] mdl [2][16];
  int          clr_left [2];
  bit          rdy_m [2];
  logic [31:0] last_m [2];
  int          edge_n  = 0;
  bit          started = 0;
  int          n_chk   = 0;
  int          n_fail  = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel, input int lanes);
    logic [31:0] r;
    r = old;
    for (int l = 0; l < lanes; l++) if (sel[l]) r[l*8 +: 8] = nw[l*8 +: 8];
    return r;
  endfunction

  // Reference behaviour at one rising edge, using the inputs as they stood before it.
  task automatic model_edge(input int d);
    logic [31:0] word;
    exp_t        e;
    bit          fire, wr_ok;
    if (rst) begin
      clr_left[d] = depth_c[d];
      rdy_m[d]    = 1'b0;
      last_m[d]   = '0;
      if (d == 0) q0.delete(); else q1.delete();
      return;
    end
    fire  = rdy_m[d] && rd_en;
    wr_ok = rdy_m[d] && wr_en && (int'(wr_adr) < depth_c[d]);
    if (fire) begin
      word = (int'(rd_adr) < depth_c[d]) ? mdl[d][rd_adr] : 32'h0;
      if (rdw_c[d] != 0 && wr_ok && wr_adr == rd_adr)
        word = merge(word, wr_dat, wr_sel, lanes_c[d]);
      e.dat = word & mask_c[d];
      e.due = edge_n + oreg_c[d];
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    if (wr_ok) mdl[d][wr_adr] = merge(mdl[d][wr_adr], wr_dat, wr_sel, lanes_c[d]) & mask_c[d];
    if (clr_left[d] > 0) begin
      clr_left[d]--;
      if (clr_left[d] == 0) begin
        for (int i = 0; i < 16; i++) mdl[d][i] = clrv_c[d];
        rdy_m[d] = 1'b1;
      end
    end
  endtask

  always @(posedge clk) begin
    edge_n++;
    model_edge(0);
    model_edge(1);
    if (rst) started = 1'b1;
  end

  task automatic cmp(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d edge %0d: got %h expected %h", name, d, edge_n, act, exp);
    end
  endtask

  task automatic check(input int d, input logic v, input logic [31:0] dat, input logic rdy);
    bit          ev;
    logic [31:0] ed;
    exp_t        e;
    ev = 1'b0;
    ed = last_m[d];
    if (d == 0 && q0.size() > 0 && q0[0].due == edge_n) begin
      ev = 1'b1;
      e  = q0.pop_front();
      ed = e.dat;
    end else if (d == 1 && q1.size() > 0 && q1[0].due == edge_n) begin
      ev = 1'b1;
      e  = q1.pop_front();
      ed = e.dat;
    end
    cmp("ready", d, {31'b0, rdy}, {31'b0, rdy_m[d]});
    cmp("rd_valid", d, {31'b0, v}, {31'b0, ev});
    cmp(ev ? "rd_dat" : "rd_dat_hold", d, dat, ed);
    last_m[d] = ed;
  endtask

  always @(negedge clk) begin
    if (started) begin
      check(0, bus0.rd_valid, bus0.rd_dat, bus0.ready);
      check(1, bus1.rd_valid, {16'h0, bus1.rd_dat}, bus1.ready);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_in(input int rd_pct);
    wr_en  = ($urandom_range(0, 99) < 40);
    rd_en  = ($urandom_range(0, 99) < rd_pct);
    wr_adr = 4'($urandom);
    wr_dat = $urandom;
    wr_sel = 4'($urandom);
    rd_adr = ($urandom_range(0, 2) == 0) ? wr_adr : 4'($urandom);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    wr_adr = '0; rd_adr = '0; wr_dat = '0; wr_sel = '0;
    tick(); tick();
    rst = 1'b0;
    // Traffic during the clear must be ignored; reset again on the 6th clear edge.
    repeat (5) begin rand_in(80); tick(); end
    rst = 1'b1; wr_en = 1'b0;
    tick();
    rst = 1'b0;
    repeat (11) begin rand_in(80); tick(); end
    wr_en = 1'b0; rd_en = 1'b0;
    repeat (5) tick();
    // Back-to-back sweep of every address straight after the clear.
    for (int a = 0; a < 16; a++) begin
      rd_en = 1'b1; rd_adr = 4'(a);
      tick();
    end
    rd_en = 1'b0;
    repeat (2000) begin
      if ($urandom_range(0, 299) == 0) begin
        rand_in(60);
        rst = 1'b1; wr_en = 1'b0;
      end else begin
        rst = 1'b0;
        rand_in(60);
      end
      tick();
    end
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    repeat (20) tick();
    cmp("drain_q0", 0, 32'(q0.size()), 32'h0);
    cmp("drain_q1", 1, 32'(q1.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
